// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 round sequencer driving the registered stage-result multiplexer
module aes_round_ctrl #(
    parameter int MUX_LAT = 2
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] res,
    output logic [3:0]   res_sel,
    output logic [127:0] state_out,
    output logic [3:0]   round_num,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
    // Op encoding order makes the one-hot select a plain right shift of 4'b1000.
    typedef enum logic [1:0] {OP_ARK, OP_SBT, OP_SHR, OP_MXC} op_e;

    fsm_e         fsm_q, fsm_d;
    op_e          op_q, op_d;
    logic [127:0] st_q, st_d;
    logic [127:0] ct_q, ct_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [2:0]   wait_q, wait_d;

    // Next-state logic: accept in IDLE, wait out the mux latency per step, then capture and advance.
    always_comb begin
        fsm_d  = fsm_q;
        op_d   = op_q;
        st_d   = st_q;
        ct_d   = ct_q;
        rnd_d  = rnd_q;
        wait_d = wait_q;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    fsm_d  = RUN;
                    st_d   = plaintext;
                    rnd_d  = 4'd0;
                    op_d   = OP_ARK;
                    wait_d = 3'd0;
                end
            end
            RUN: begin
                if (wait_q < 3'(MUX_LAT)) begin
                    wait_d = wait_q + 3'd1;
                end else begin
                    wait_d = 3'd0;
                    st_d   = res;
                    case (op_q)
                        OP_ARK: begin
                            if (rnd_q == 4'd10) begin
                                ct_d  = res;
                                fsm_d = DONE;
                            end else begin
                                rnd_d = rnd_q + 4'd1;
                                op_d  = OP_SBT;
                            end
                        end
                        OP_SBT:  op_d = OP_SHR;
                        OP_SHR:  op_d = (rnd_q == 4'd10) ? OP_ARK : OP_MXC;
                        default: op_d = OP_ARK;
                    endcase
                end
            end
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // State register with asynchronous clear of every output-visible flop.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fsm_q  <= IDLE;
            op_q   <= OP_ARK;
            st_q   <= '0;
            ct_q   <= '0;
            rnd_q  <= 4'd0;
            wait_q <= 3'd0;
        end else begin
            fsm_q  <= fsm_d;
            op_q   <= op_d;
            st_q   <= st_d;
            ct_q   <= ct_d;
            rnd_q  <= rnd_d;
            wait_q <= wait_d;
        end
    end

    // Outputs decode purely from registered state so they stay stable for a whole step.
    always_comb begin
        busy       = (fsm_q == RUN);
        done       = (fsm_q == DONE);
        res_sel    = busy ? (4'b1000 >> op_q) : 4'b0000;
        state_out  = st_q;
        round_num  = rnd_q;
        ciphertext = ct_q;
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: AES stage models, registered mux and key schedule around the round sequencer
module tb_aes_round_ctrl;

    parameter int MUX_LAT = 2;
    localparam int STEP = MUX_LAT + 1;
    localparam int LT   = 40 * STEP;

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] res;
    logic [3:0]   res_sel;
    logic [127:0] state_out;
    logic [3:0]   round_num;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;

    aes_round_ctrl #(.MUX_LAT(MUX_LAT)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .plaintext(plaintext), .res(res),
        .res_sel(res_sel), .state_out(state_out), .round_num(round_num),
        .busy(busy), .done(done), .ciphertext(ciphertext)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [127:0] ct;
        int           at;
    } exp_t;
    exp_t sb[$];

    logic [127:0] rk[16];

    function automatic logic [7:0] xt(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(logic [7:0] x);
        logic [7:0] b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(logic [127:0] s);
        for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return s;
    endfunction

    function automatic logic [127:0] shift_rows(logic [127:0] s);
        logic [127:0] o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(logic [127:0] s);
        logic [127:0] o = '0;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int r = 11; r < 16; r++) rk[r] = '0;
    endtask

    function automatic logic [127:0] aes_ref(logic [127:0] pt);
        logic [127:0] s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r < 10) s = mix_cols(s);
            s = s ^ rk[r];
        end
        return s;
    endfunction

    function automatic logic [3:0] exp_sel(int s);
        if (s == 0) return 4'b1000;
        if (s == 37) return 4'b0100;
        if (s == 38) return 4'b0010;
        if (s == 39) return 4'b1000;
        case ((s - 1) % 4)
            0:       return 4'b0100;
            1:       return 4'b0010;
            2:       return 4'b0001;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [3:0] exp_rnd(int s);
        return 4'((s + 3) / 4);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stage units and the MUX_LAT-deep registered result multiplexer.
    logic [127:0] stage;
    always_comb begin
        stage = '0;
        case (res_sel)
            4'b1000: stage = state_out ^ rk[round_num];
            4'b0100: stage = sub_bytes(state_out);
            4'b0010: stage = shift_rows(state_out);
            4'b0001: stage = mix_cols(state_out);
            default: stage = '0;
        endcase
    end

    logic [127:0] pipe[MUX_LAT];
    always @(posedge Clk) begin
        pipe[0] <= stage;
        for (int i = 1; i < MUX_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign res = pipe[MUX_LAT-1];

    // Per-cycle select trace and scoreboard pop on each done pulse.
    int   trk_e0 = 0;
    bit   trk_on = 1'b0;
    int   mk;
    exp_t me;
    always @(negedge Clk) begin
        if (trk_on && cyc >= trk_e0 && cyc < trk_e0 + LT) begin
            mk = (cyc - trk_e0) / STEP;
            chk("res_sel", 128'(res_sel), 128'(exp_sel(mk)));
            chk("round_num", 128'(round_num), 128'(exp_rnd(mk)));
            chk("busy_run", 128'(busy), 128'(1));
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 128'(done), 128'(0));
            end else begin
                me = sb.pop_front();
                chk("ciphertext", ciphertext, me.ct);
                chk("done_cycle", 128'(cyc), 128'(me.at));
                chk("done_busy", 128'(busy), 128'(0));
                chk("done_sel", 128'(res_sel), 128'(0));
            end
        end
    end

    task automatic launch(input logic [127:0] pt, input logic [127:0] ct);
        plaintext = pt;
        start = 1'b1;
        trk_e0 = cyc + 1;
        trk_on = 1'b1;
        sb.push_back('{ct, cyc + 1 + LT});
        @(negedge Clk);
        start = 1'b0;
        plaintext = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n && sb.size() != 0; i++) @(negedge Clk);
        repeat (2) @(negedge Clk);
        chk("drain", 128'(sb.size()), 128'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sel"}, 128'(res_sel), 128'(0));
        chk({tag, "_state"}, state_out, 128'(0));
        chk({tag, "_round"}, 128'(round_num), 128'(0));
        chk({tag, "_ct"}, ciphertext, 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p1, p2;
        int e0, nd;
        // Reset held with start already high: accept on the first edge after release.
        set_key(B_KEY);
        start = 1'b1;
        plaintext = B_PT;
        repeat (2) @(negedge Clk);
        chk_zero("reset");
        trk_e0 = cyc + 1;
        trk_on = 1'b1;
        sb.push_back('{B_CT, cyc + 1 + LT});
        Rst = 1'b0;
        @(negedge Clk);
        start = 1'b0;
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        drain(LT + 20);
        // FIPS-197 C.1
        set_key(C_KEY);
        launch(C_PT, C_CT);
        drain(LT + 20);
        // start held high for 200 cycles with plaintext churning during RUN
        p1 = {$urandom, $urandom, $urandom, $urandom};
        plaintext = p1;
        start = 1'b1;
        e0 = cyc + 1;
        trk_e0 = e0;
        trk_on = 1'b1;
        sb.push_back('{aes_ref(p1), e0 + LT});
        nd = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk);
            if (k <= LT && done) nd++;
            if (k == LT) chk("one_done", 128'(nd), 128'(1));
            if (k == LT + 1) begin
                chk("gap_busy", 128'(busy), 128'(0));
                p2 = {$urandom, $urandom, $urandom, $urandom};
                plaintext = p2;
                trk_e0 = cyc + 1;
                sb.push_back('{aes_ref(p2), cyc + 1 + LT});
            end else begin
                plaintext = {$urandom, $urandom, $urandom, $urandom};
            end
            if (k == LT + 2) chk("second_accept", 128'(cyc), 128'(e0 + LT + 2));
            if (k == LT + 2) chk("second_busy", 128'(busy), 128'(1));
        end
        start = 1'b0;
        drain(LT + 50);
        // Reset pulse mid-run: everything clears, no done follows
        set_key(B_KEY);
        plaintext = B_PT;
        start = 1'b1;
        e0 = cyc + 1;
        trk_e0 = e0;
        trk_on = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (49) @(negedge Clk);
        chk("pre_rst_busy", 128'(busy), 128'(1));
        trk_on = 1'b0;
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1 chk_zero("midrst");
        @(negedge Clk);
        Rst = 1'b0;
        repeat (LT) @(negedge Clk);
        chk("post_rst_busy", 128'(busy), 128'(0));
        chk("post_rst_sel", 128'(res_sel), 128'(0));
        // App. B again after the aborted run
        launch(B_PT, B_CT);
        drain(LT + 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
